// File: rtl/nbf_rx_framer.sv
// nbf_rx_framer: assembles fixed-size NBF packets from a valid/ready byte stream with timeout, flush and drop count
module nbf_rx_framer #(
    parameter int nbf_opcode_width_p = 8,
    parameter int nbf_addr_width_p   = 40,
    parameter int nbf_data_width_p   = 64,
    parameter int byte_width_p       = 8,
    parameter int timeout_clks_p     = 65536,
    parameter int drop_count_width_p = 8,
    localparam int nbf_width_lp      = nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          byte_v_i,
    input  logic [byte_width_p-1:0]       byte_i,
    output logic                          byte_ready_and_o,
    input  logic                          flush_i,
    output logic                          nbf_v_o,
    output logic [nbf_width_lp-1:0]       nbf_o,
    input  logic                          nbf_ready_and_i,
    output logic                          busy_o,
    output logic                          timeout_o,
    output logic [drop_count_width_p-1:0] drop_count_o
);
    localparam int nbf_bytes_lp = nbf_width_lp / byte_width_p;
    localparam int cnt_w_lp     = nbf_bytes_lp > 1 ? $clog2(nbf_bytes_lp) : 1;
    localparam int tmr_w_lp     = $clog2(timeout_clks_p);

    typedef enum logic [1:0] {e_idle, e_collect, e_valid} state_e;

    state_e                state_r;
    logic [cnt_w_lp-1:0]   count_r;
    logic [tmr_w_lp-1:0]   tcnt_r;
    logic                  byte_xfer, pkt_xfer, tmo, last;
    logic [cnt_w_lp-1:0]   idx;

    // In e_valid a new byte may only enter when the held packet leaves the same cycle.
    assign byte_ready_and_o = ~reset_i & ~flush_i & ((state_r == e_valid) ? nbf_ready_and_i : 1'b1);
    assign byte_xfer = byte_v_i & byte_ready_and_o;
    assign pkt_xfer  = nbf_v_o & nbf_ready_and_i;
    assign idx       = (state_r == e_collect) ? count_r : '0;
    assign last      = idx == cnt_w_lp'(nbf_bytes_lp - 1);
    assign tmo       = (state_r == e_collect) & ~byte_xfer & (tcnt_r == tmr_w_lp'(timeout_clks_p - 2));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= e_idle;
            count_r      <= '0;
            tcnt_r       <= '0;
            nbf_o        <= '0;
            nbf_v_o      <= 1'b0;
            busy_o       <= 1'b0;
            timeout_o    <= 1'b0;
            drop_count_o <= '0;
        end else begin
            timeout_o <= 1'b0;
            if (flush_i) begin
                state_r <= e_idle;
                count_r <= '0;
                tcnt_r  <= '0;
                nbf_v_o <= 1'b0;
                busy_o  <= 1'b0;
                if (state_r == e_collect && drop_count_o != '1)
                    drop_count_o <= drop_count_o + 1'b1;
            end else if (byte_xfer) begin
                nbf_o[int'(idx)*byte_width_p +: byte_width_p] <= byte_i;
                state_r <= last ? e_valid : e_collect;
                count_r <= last ? '0 : idx + 1'b1;
                tcnt_r  <= '0;
                nbf_v_o <= last;
                busy_o  <= ~last;
            end else if (pkt_xfer) begin
                state_r <= e_idle;
                nbf_v_o <= 1'b0;
            end else if (tmo) begin
                state_r   <= e_idle;
                count_r   <= '0;
                tcnt_r    <= '0;
                busy_o    <= 1'b0;
                timeout_o <= 1'b1;
                if (drop_count_o != '1)
                    drop_count_o <= drop_count_o + 1'b1;
            end else if (state_r == e_collect) begin
                tcnt_r <= tcnt_r + 1'b1;
            end
        end
    end
endmodule

// File: doc/nbf_rx_framer.md
Name: nbf_rx_framer

Overview:
Parametrised byte-stream to NBF packet framer for the FPGA host path. It sits between uart_rx and the host's NBF input buffer. It assembles fixed-size NBF packets from a valid/ready byte stream of configurable byte width. Beyond the existing fixed 14-byte, 8-bit deserialisation, it adds:
- inter-byte timeout resynchronisation;
- a flush input;
- same-cycle output handoff;
- a saturating dropped-packet counter.

Parameters:
nbf_opcode_width_p, 8, opcode field width in bits
nbf_addr_width_p, 40, address field width in bits
nbf_data_width_p, 64, data field width in bits
byte_width_p, 8, width of one input beat; (opcode+addr+data) must be an exact multiple of it
timeout_clks_p, 65536, idle cycles allowed between bytes inside a packet; must be >= 2
drop_count_width_p, 8, width of the dropped-packet counter

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
byte_v_i  in  1  input byte valid
byte_i  in  byte_width_p  input byte
byte_ready_and_o  out  1  framer accepts byte this cycle
flush_i  in  1  discard partial and pending packet
nbf_v_o  out  1  assembled packet valid
nbf_o  out  nbf_width_lp (= opcode+addr+data)  packet {data, addr, opcode}, opcode in LSBs
nbf_ready_and_i  in  1  consumer accepts packet
busy_o  out  1  partial packet in progress
timeout_o  out  1  one-cycle pulse when a partial packet is discarded by timeout
drop_count_o  out  drop_count_width_p  saturating count of discarded partial packets

Behaviour:
- nbf_bytes_lp = nbf_width_lp / byte_width_p; with the defaults this is 14.
- A byte transfers when byte_v_i & byte_ready_and_o.
- A packet transfers when nbf_v_o & nbf_ready_and_i.
- Byte k of a packet (k = 0 first) is written to nbf_o[k*byte_width_p +: byte_width_p], so the first byte lands in the LSBs.
- Reset values: state e_idle, byte count 0, timeout counter 0, nbf_o 0, nbf_v_o 0, busy_o 0, timeout_o 0, drop_count_o 0. byte_ready_and_o is 0 while reset_i is high.
- States: e_idle, e_collect, e_valid.
- e_idle:
  - byte_ready_and_o = 1.
  - On a byte transfer: store byte 0, set count = 1, clear the timeout counter.
  - Next state is e_collect, or e_valid when nbf_bytes_lp == 1.
- e_collect:
  - byte_ready_and_o = 1, busy_o = 1.
  - On a byte transfer: store at index count, count++, clear the timeout counter.
  - When the byte at index nbf_bytes_lp-1 transfers, go to e_valid on the next cycle.
  - On a cycle with no byte transfer, the timeout counter increments.
  - When the counter reaches timeout_clks_p-1 with no transfer:
    - discard the partial packet and go to e_idle;
    - pulse timeout_o for one cycle;
    - increment drop_count_o, saturating at all-ones.
- e_valid:
  - nbf_v_o = 1; nbf_o is held stable until the packet transfers.
  - byte_ready_and_o = nbf_ready_and_i; this is a combinational path, by design.
  - Packet transfer with no byte transfer: next state e_idle.
  - Packet and byte transfer in the same cycle: store the byte as byte 0 of the next packet, count = 1, next state e_collect (zero-bubble back-to-back).
  - No timeout is counted in e_valid.
- Latency: nbf_v_o rises on the cycle after the final byte transfers.
- flush_i has priority over everything:
  - Forces byte_ready_and_o = 0 that cycle, so no byte transfers.
  - Next state e_idle; count and timeout counter cleared.
  - Any pending e_valid packet is dropped and nbf_v_o falls on the next cycle.
  - If flush_i is asserted in e_collect, drop_count_o increments (saturating); no timeout_o pulse.
  - If flush_i is asserted in e_idle or e_valid, drop_count_o is unchanged.
  - drop_count_o and timeout_o change only as stated above.
- Reset mid-packet: all state returns to reset values on the next edge, and the partial packet is lost.
- nbf_o contents are don't-care except when nbf_v_o = 1. Unwritten byte lanes of a new packet may hold stale data until overwritten.

Test Plan:
- Fence packet: send 14 bytes {0xFE, then 13× 0x00} with nbf_ready_and_i = 1 -> nbf_v_o high the cycle after byte 13, nbf_o[7:0] = 0xFE, all other bits 0; drop_count_o = 0.
- Back-to-back write_8 packets, data byte 0x00 then 0x01, with the second packet's byte 0 presented during e_valid while nbf_ready_and_i = 1 -> two packets delivered with no dropped byte; second packet has nbf_o[55:48] = 0x01 (data LSB sits at bit 48).
- Backpressure: hold nbf_ready_and_i = 0 for 50 cycles after a packet completes -> nbf_v_o and nbf_o stable, byte_ready_and_o = 0 throughout; raising nbf_ready_and_i releases the packet.
- Timeout: timeout_clks_p = 16; send 5 bytes then idle -> timeout_o pulses once 15 cycles after byte 5, busy_o falls, drop_count_o = 1; a following full 14-byte packet frames correctly from byte 0.
- Flush: flush_i asserted after 7 bytes with byte_v_i also high -> that byte not accepted, drop_count_o = 1, no timeout_o pulse; flush_i during e_valid -> packet never delivered, drop_count_o unchanged.
- Saturation and width: drop_count_width_p = 2 with 5 forced timeouts -> drop_count_o sticks at 3. Separately, byte_width_p = 16, nbf_addr_width_p = 40, nbf_data_width_p = 64 -> 7 beats frame one packet with beat 0 in bits [15:0].
